// File: rtl/cordic_pkg.sv
// Shared types and constants for the CORDIC sequencer, init stage and iteration datapath.
package cordic_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StLoad,
      StIter,
      StDone
   } cordic_state_e;

   localparam logic MODE_ROT = 1'b0;
   localparam logic MODE_VEC = 1'b1;

   localparam int unsigned N_ITER_DEF = 16;
   localparam int unsigned OPW        = 16;
   localparam int unsigned DPW        = 24;

   // Bit 3 of the operation select picks vectoring over rotation.
   function automatic logic is_vec(input logic [3:0] sel);
      return sel[3] == MODE_VEC;
   endfunction

endpackage

// File: rtl/cordic_seq_ctrl_if.sv
// Request, init-stage, iteration and result signals of cordic_seq_ctrl.
// The abort input exists only when CORDIC_SEQ_ABORT_EN is defined.
interface cordic_seq_ctrl_if
   import cordic_pkg::*;
#(
   parameter int unsigned ITW = 5
) ();

   logic           req_valid;
   logic           req_ready;
   logic [3:0]     req_select;
   logic [OPW-1:0] req_angle;
   logic [OPW-1:0] req_another;
   logic           init_valid;
   logic [3:0]     init_select;
   logic [OPW-1:0] init_angle;
   logic [OPW-1:0] init_another;
   logic           iter_en;
   logic [ITW-1:0] iter_idx;
   logic           iter_mode;
   logic           res_valid;
   logic           res_ready;
   logic           busy;
   logic [15:0]    op_count;

`ifdef CORDIC_SEQ_ABORT_EN
   logic           abort;

   modport slave (
      input  req_valid, req_select, req_angle, req_another, res_ready, abort,
      output req_ready, init_valid, init_select, init_angle, init_another,
             iter_en, iter_idx, iter_mode, res_valid, busy, op_count
   );

   modport master (
      output req_valid, req_select, req_angle, req_another, res_ready, abort,
      input  req_ready, init_valid, init_select, init_angle, init_another,
             iter_en, iter_idx, iter_mode, res_valid, busy, op_count
   );
`else
   modport slave (
      input  req_valid, req_select, req_angle, req_another, res_ready,
      output req_ready, init_valid, init_select, init_angle, init_another,
             iter_en, iter_idx, iter_mode, res_valid, busy, op_count
   );

   modport master (
      output req_valid, req_select, req_angle, req_another, res_ready,
      input  req_ready, init_valid, init_select, init_angle, init_another,
             iter_en, iter_idx, iter_mode, res_valid, busy, op_count
   );
`endif

endinterface

// File: rtl/cordic_iter_cnt.sv
// Micro-rotation index counter: clear beats load beats enable; term_o flags the last index.
module cordic_iter_cnt #(
   parameter int unsigned N_ITER = 16,
   parameter int unsigned ITW    = 5
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           clr_i,
   input  logic           load_i,
   input  logic [ITW-1:0] load_val_i,
   input  logic           en_i,
   output logic [ITW-1:0] count_o,
   output logic           term_o
);

   localparam logic [ITW-1:0] TermVal = ITW'(N_ITER - 1);

   logic [ITW-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = '0;
      end else if (load_i) begin
         count_d = load_val_i;
      end else if (en_i) begin
         count_d = count_q + ITW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;
   assign term_o  = (count_q == TermVal);

endmodule

// File: rtl/cordic_seq_ctrl.sv
// Sequencer for the iterative CORDIC core: accept, load strobe, N_ITER steps, held result.
// Optional abort input enabled by defining CORDIC_SEQ_ABORT_EN.
module cordic_seq_ctrl
   import cordic_pkg::*;
#(
   parameter int unsigned N_ITER = N_ITER_DEF,
   parameter int unsigned ITW    = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   cordic_seq_ctrl_if.slave  bus
);

   cordic_state_e  state_q;
   logic           req_ready_q;
   logic           init_valid_q;
   logic           iter_en_q;
   logic           res_valid_q;
   logic           busy_q;
   logic           iter_mode_q;
   logic [3:0]     init_select_q;
   logic [OPW-1:0] init_angle_q;
   logic [OPW-1:0] init_another_q;
   logic [15:0]    op_count_q;

   logic           abort_w;
   logic           accept;
   logic           cnt_clr;
   logic           cnt_load;
   logic           cnt_en;
   logic           cnt_term;
   logic [ITW-1:0] cnt_val;

`ifdef CORDIC_SEQ_ABORT_EN
   assign abort_w = bus.abort;
`else
   assign abort_w = 1'b0;
`endif

   // Abort suppresses a same-edge accept even though it is otherwise ignored in idle.
   assign accept = req_ready_q & bus.req_valid & ~abort_w;

   assign cnt_clr  = (abort_w && (state_q != StIdle)) || ((state_q == StIter) && cnt_term);
   assign cnt_load = (state_q == StLoad);
   assign cnt_en   = (state_q == StIter);

   cordic_iter_cnt #(
      .N_ITER (N_ITER),
      .ITW    (ITW)
   ) u_iter_cnt (
      .clk        (clk),
      .rst_n      (rst_n),
      .clr_i      (cnt_clr),
      .load_i     (cnt_load),
      .load_val_i ('0),
      .en_i       (cnt_en),
      .count_o    (cnt_val),
      .term_o     (cnt_term)
   );

   // Outputs are registered alongside the state so they change together on the same edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= StIdle;
         req_ready_q    <= 1'b1;
         init_valid_q   <= 1'b0;
         iter_en_q      <= 1'b0;
         res_valid_q    <= 1'b0;
         busy_q         <= 1'b0;
         iter_mode_q    <= MODE_ROT;
         init_select_q  <= '0;
         init_angle_q   <= '0;
         init_another_q <= '0;
         op_count_q     <= '0;
      end else begin
         init_valid_q <= 1'b0;
         if (abort_w && (state_q != StIdle)) begin
            state_q     <= StIdle;
            req_ready_q <= 1'b1;
            iter_en_q   <= 1'b0;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
         end else begin
            unique case (state_q)
               StIdle: begin
                  if (accept) begin
                     state_q        <= StLoad;
                     req_ready_q    <= 1'b0;
                     init_valid_q   <= 1'b1;
                     busy_q         <= 1'b1;
                     iter_mode_q    <= is_vec(bus.req_select);
                     init_select_q  <= bus.req_select;
                     init_angle_q   <= bus.req_angle;
                     init_another_q <= bus.req_another;
                  end
               end
               StLoad: begin
                  state_q   <= StIter;
                  iter_en_q <= 1'b1;
               end
               StIter: begin
                  if (cnt_term) begin
                     state_q     <= StDone;
                     iter_en_q   <= 1'b0;
                     res_valid_q <= 1'b1;
                  end
               end
               StDone: begin
                  if (bus.res_ready) begin
                     state_q     <= StIdle;
                     res_valid_q <= 1'b0;
                     req_ready_q <= 1'b1;
                     busy_q      <= 1'b0;
                     op_count_q  <= op_count_q + 16'd1;
                  end
               end
               default: begin
                  state_q     <= StIdle;
                  req_ready_q <= 1'b1;
                  iter_en_q   <= 1'b0;
                  res_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
               end
            endcase
         end
      end
   end

   assign bus.req_ready    = req_ready_q;
   assign bus.init_valid   = init_valid_q;
   assign bus.init_select  = init_select_q;
   assign bus.init_angle   = init_angle_q;
   assign bus.init_another = init_another_q;
   assign bus.iter_en      = iter_en_q;
   assign bus.iter_idx     = iter_en_q ? cnt_val : '0;
   assign bus.iter_mode    = iter_mode_q;
   assign bus.res_valid    = res_valid_q;
   assign bus.busy         = busy_q;
   assign bus.op_count     = op_count_q;

endmodule

// File: tb/tb_cordic_seq_ctrl.sv
// Scoreboard bench for cordic_seq_ctrl; exercises abort too when CORDIC_SEQ_ABORT_EN is defined.
module tb_cordic_seq_ctrl;
   import cordic_pkg::*;

   localparam int unsigned N_ITER = 16;
   localparam int unsigned ITW    = 5;
   // Accept-to-accept spacing: LOAD + N_ITER x ITER + DONE + IDLE.
   localparam int unsigned PERIOD = N_ITER + 3;
   localparam int unsigned OBSW   = 58 + ITW;
   localparam logic [OBSW-1:0] RESET_VEC = {1'b1, {(OBSW-1){1'b0}}};

   typedef struct {
      logic [3:0]  sel;
      logic [15:0] angle;
      logic [15:0] another;
      logic [15:0] count;
      int          cyc;
   } exp_t;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b1;
   int          checks = 0;
   int          errors = 0;
   logic [15:0] exp_count = 16'd0;
   exp_t        sb[$];

   cordic_seq_ctrl_if #(.ITW(ITW)) bus ();

   cordic_seq_ctrl #(
      .N_ITER (N_ITER),
      .ITW    (ITW)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [OBSW-1:0] obs_vec();
      return {bus.req_ready, bus.init_valid, bus.iter_en, bus.iter_idx, bus.iter_mode,
              bus.res_valid, bus.busy, bus.op_count, bus.init_select, bus.init_angle,
              bus.init_another};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Pushes the expected operation, presents it for cycle 0 and returns in cycle 1.
   task automatic issue(input logic [3:0] sel, input logic [15:0] ang, input logic [15:0] oth);
      exp_t e;
      e.sel     = sel;
      e.angle   = ang;
      e.another = oth;
      e.count   = exp_count + 16'd1;
      e.cyc     = 0;
      sb.push_back(e);
      bus.req_select  = sel;
      bus.req_angle   = ang;
      bus.req_another = oth;
      bus.req_valid   = 1'b1;
      step();
      bus.req_valid = 1'b0;
   endtask

   task automatic test_reset();
      bus.req_valid   = 1'b0;
      bus.req_select  = 4'h0;
      bus.req_angle   = 16'h0;
      bus.req_another = 16'h0;
      bus.res_ready   = 1'b1;
`ifdef CORDIC_SEQ_ABORT_EN
      bus.abort = 1'b0;
`endif
      #1 rst_n = 1'b0;
      #2;
      checks++;
      if (obs_vec() !== RESET_VEC)
         begin errors++; $display("FAIL reset_async got %h want %h", obs_vec(), RESET_VEC); end
      step();
      step();
      checks++;
      if (obs_vec() !== RESET_VEC)
         begin errors++; $display("FAIL reset_held got %h want %h", obs_vec(), RESET_VEC); end
      rst_n = 1'b1;
      step();
      step();
      checks++;
      if (obs_vec() !== RESET_VEC)
         begin errors++; $display("FAIL reset_release got %h want %h", obs_vec(), RESET_VEC); end
   endtask

   task automatic test_rotation();
      exp_t e;
      issue(4'h0, 16'd30, 16'd0);
      checks++;
      if (bus.init_valid !== 1'b1 || bus.init_angle !== sb[0].angle || bus.init_select !== sb[0].sel)
         begin errors++; $display("FAIL rot_load got v=%b ang=%0d sel=%h want v=1 ang=%0d sel=%h",
                                  bus.init_valid, bus.init_angle, bus.init_select, sb[0].angle,
                                  sb[0].sel); end
      checks++;
      if ({bus.busy, bus.req_ready, bus.iter_en} !== 3'b100)
         begin errors++; $display("FAIL rot_load_flags got busy/rdy/en=%b%b%b want 100",
                                  bus.busy, bus.req_ready, bus.iter_en); end
      for (int i = 0; i < N_ITER; i++) begin
         step();
         checks++;
         if (bus.iter_en !== 1'b1 || bus.iter_idx !== ITW'(i) || bus.init_valid !== 1'b0 ||
             bus.res_valid !== 1'b0)
            begin errors++; $display("FAIL rot_iter cyc=%0d got en=%b idx=%0d iv=%b rv=%b want en=1 idx=%0d iv=0 rv=0",
                                     i + 2, bus.iter_en, bus.iter_idx, bus.init_valid,
                                     bus.res_valid, i); end
      end
      step();
      checks++;
      if (bus.res_valid !== 1'b1 || bus.iter_en !== 1'b0 || bus.iter_idx !== '0)
         begin errors++; $display("FAIL rot_done got rv=%b en=%b idx=%0d want rv=1 en=0 idx=0",
                                  bus.res_valid, bus.iter_en, bus.iter_idx); end
      step();
      e = sb.pop_front();
      exp_count = e.count;
      checks++;
      if (bus.op_count !== e.count || bus.req_ready !== 1'b1 || bus.res_valid !== 1'b0)
         begin errors++; $display("FAIL rot_handshake got cnt=%0d rdy=%b rv=%b want cnt=%0d rdy=1 rv=0",
                                  bus.op_count, bus.req_ready, bus.res_valid, e.count); end
   endtask

   task automatic test_vectoring();
      exp_t e;
      logic [15:0] neg50 = -16'sd50;
      issue(4'h8, 16'd100, neg50);
      checks++;
      if (bus.init_another !== sb[0].another || bus.init_angle !== sb[0].angle ||
          bus.init_another !== 16'hFFCE)
         begin errors++; $display("FAIL vec_operands got ang=%h oth=%h want ang=%h oth=%h",
                                  bus.init_angle, bus.init_another, sb[0].angle,
                                  sb[0].another); end
      for (int c = 1; c <= N_ITER + 2; c++) begin
         checks++;
         if (bus.iter_mode !== MODE_VEC)
            begin errors++; $display("FAIL vec_mode cyc=%0d got %b want 1", c, bus.iter_mode); end
         step();
      end
      e = sb.pop_front();
      exp_count = e.count;
      checks++;
      if (bus.op_count !== e.count || bus.busy !== 1'b0)
         begin errors++; $display("FAIL vec_handshake got cnt=%0d busy=%b want cnt=%0d busy=0",
                                  bus.op_count, bus.busy, e.count); end
   endtask

   task automatic test_backpressure();
      exp_t e;
      int   k = 0;
      bus.res_ready = 1'b0;
      issue(4'h1, 16'd7, 16'd0);
      while (bus.res_valid !== 1'b1 && k < N_ITER + 4) begin
         step();
         k++;
      end
      checks++;
      if (k != N_ITER + 1)
         begin errors++; $display("FAIL bp_latency got %0d cycles want %0d", k + 1, N_ITER + 2); end
      for (int i = 0; i < 10; i++) begin
         step();
         checks++;
         if (bus.res_valid !== 1'b1 || bus.iter_en !== 1'b0 || bus.req_ready !== 1'b0 ||
             bus.op_count !== exp_count)
            begin errors++; $display("FAIL bp_hold i=%0d got rv=%b en=%b rdy=%b cnt=%0d want rv=1 en=0 rdy=0 cnt=%0d",
                                     i, bus.res_valid, bus.iter_en, bus.req_ready, bus.op_count,
                                     exp_count); end
      end
      bus.res_ready = 1'b1;
      step();
      e = sb.pop_front();
      exp_count = e.count;
      checks++;
      if (bus.req_ready !== 1'b1 || bus.busy !== 1'b0 || bus.op_count !== e.count)
         begin errors++; $display("FAIL bp_release got rdy=%b busy=%b cnt=%0d want rdy=1 busy=0 cnt=%0d",
                                  bus.req_ready, bus.busy, bus.op_count, e.count); end
   endtask

   task automatic test_back_to_back();
      exp_t e;
      int   pulses = 0;
      for (int c = 0; c <= 3 * PERIOD + 2; c++) begin
         if (bus.init_valid === 1'b1) begin
            pulses++;
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL b2b_extra_accept cyc=%0d got ang=%0d want none", c, bus.init_angle);
            end else begin
               e = sb.pop_front();
               if (c != e.cyc + 1 || bus.init_angle !== e.angle || bus.init_select !== e.sel ||
                   bus.init_another !== e.another)
                  begin errors++; $display("FAIL b2b_accept got cyc=%0d ang=%0d sel=%h want cyc=%0d ang=%0d sel=%h",
                                           c, bus.init_angle, bus.init_select, e.cyc + 1,
                                           e.angle, e.sel); end
            end
         end
         if (c < 3 * PERIOD) begin
            bus.req_valid   = 1'b1;
            bus.req_select  = 4'(c);
            bus.req_angle   = 16'(1000 + c);
            bus.req_another = 16'(c);
            if (c % PERIOD == 0) begin
               e.sel     = 4'(c);
               e.angle   = 16'(1000 + c);
               e.another = 16'(c);
               e.count   = 16'd0;
               e.cyc     = c;
               sb.push_back(e);
            end
         end else begin
            bus.req_valid = 1'b0;
         end
         step();
      end
      exp_count = exp_count + 16'd3;
      checks++;
      if (pulses != 3 || sb.size() != 0)
         begin errors++; $display("FAIL b2b_count got pulses=%0d pending=%0d want pulses=3 pending=0",
                                  pulses, sb.size()); sb.delete(); end
      checks++;
      if (bus.op_count !== exp_count || bus.busy !== 1'b0)
         begin errors++; $display("FAIL b2b_opcount got cnt=%0d busy=%b want cnt=%0d busy=0",
                                  bus.op_count, bus.busy, exp_count); end
   endtask

   task automatic test_async_reset();
      exp_t e;
      int   k = 0;
      int   n = 0;
      int   bad = 0;
      issue(4'h0, 16'd55, 16'd0);
      while (!(bus.iter_en === 1'b1 && bus.iter_idx === ITW'(7)) && k < N_ITER + 4) begin
         step();
         k++;
      end
      checks++;
      if (k != 8)
         begin errors++; $display("FAIL arst_reach_idx7 got %0d steps want 8", k); end
      #2 rst_n = 1'b0;
      #1;
      void'(sb.pop_front());
      exp_count = 16'd0;
      checks++;
      if (obs_vec() !== RESET_VEC)
         begin errors++; $display("FAIL arst_midop got %h want %h", obs_vec(), RESET_VEC); end
      step();
      rst_n = 1'b1;
      step();
      issue(4'h0, 16'd60, 16'd0);
      for (int i = 0; i < PERIOD + 1; i++) begin
         step();
         if (bus.iter_en === 1'b1) begin
            if (bus.iter_idx !== ITW'(n)) bad++;
            n++;
         end
      end
      checks++;
      if (n != N_ITER || bad != 0)
         begin errors++; $display("FAIL arst_rerun got iters=%0d badidx=%0d want iters=%0d badidx=0",
                                  n, bad, N_ITER); end
      e = sb.pop_front();
      exp_count = e.count;
      checks++;
      if (bus.op_count !== e.count || bus.req_ready !== 1'b1)
         begin errors++; $display("FAIL arst_opcount got cnt=%0d rdy=%b want cnt=%0d rdy=1",
                                  bus.op_count, bus.req_ready, e.count); end
   endtask

`ifdef CORDIC_SEQ_ABORT_EN
   task automatic test_abort();
      int k = 0;
      int seen_rv = 0;
      issue(4'h0, 16'd77, 16'd0);
      while (!(bus.iter_en === 1'b1 && bus.iter_idx === ITW'(5)) && k < N_ITER + 4) begin
         step();
         k++;
      end
      bus.abort = 1'b1;
      step();
      bus.abort = 1'b0;
      void'(sb.pop_front());
      checks++;
      if (bus.req_ready !== 1'b1 || bus.busy !== 1'b0 || bus.iter_en !== 1'b0)
         begin errors++; $display("FAIL abort_idle got rdy=%b busy=%b en=%b want rdy=1 busy=0 en=0",
                                  bus.req_ready, bus.busy, bus.iter_en); end
      for (int i = 0; i < PERIOD; i++) begin
         if (bus.res_valid === 1'b1) seen_rv++;
         step();
      end
      checks++;
      if (seen_rv != 0 || bus.op_count !== exp_count)
         begin errors++; $display("FAIL abort_noresult got rv_cycles=%0d cnt=%0d want rv_cycles=0 cnt=%0d",
                                  seen_rv, bus.op_count, exp_count); end
   endtask
`endif

   initial begin
      test_reset();
      test_rotation();
      test_vectoring();
      test_backpressure();
      test_back_to_back();
      test_async_reset();
`ifdef CORDIC_SEQ_ABORT_EN
      test_abort();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "timeout");
   end

endmodule
